// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Contents:
//   REG_W_DEFAULT - default register-index width.
//   ctrl_state_e  - sequencer state encoding (RUN/LDUSE/REDIR/MEMWAIT).
package pipe_hazard_ctrl_pkg;

  localparam int REG_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDUSE   = 2'd1,
    ST_REDIR   = 2'd2,
    ST_MEMWAIT = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// hazard_cmp: combinational load-use comparator.
// Flags when the load in E writes a register that the instruction in D reads.
// Register index 0 is treated like any other index.
// Ports:
//   d_src1, d_src2   in  source register indices of the D instruction
//   d_use1, d_use2   in  D instruction actually reads src1 / src2
//   e_dest           in  destination register index of the E instruction
//   e_reg_wr_en      in  E instruction writes a register
//   e_is_lw          in  E instruction is a load
//   ldhaz            out load-use hazard detected
module hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEFAULT
) (
  input  logic [REG_W-1:0] d_src1,
  input  logic [REG_W-1:0] d_src2,
  input  logic             d_use1,
  input  logic             d_use2,
  input  logic [REG_W-1:0] e_dest,
  input  logic             e_reg_wr_en,
  input  logic             e_is_lw,
  output logic             ldhaz
);

  logic match1_s;
  logic match2_s;

  assign match1_s = d_use1 & (d_src1 == e_dest);
  assign match2_s = d_use2 & (d_src2 == e_dest);
  assign ldhaz    = e_is_lw & e_reg_wr_en & (match1_s | match2_s);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush sequencer for the PC and the F/D/E
// pipeline buffers. Each buffer's stall/flush strobe is driven only here.
//
// Event priority each cycle: data-memory wait > E-stage redirect > load-use.
// Strobes are Mealy outputs (valid in the cycle the event is seen) and are
// all forced low while reset_n is low.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   d_src1/d_src2/d_use1/d_use2  D-stage source operands
//   e_dest/e_reg_wr_en/e_is_lw   E-stage destination info
//   e_redirect                   E resolved a taken branch/jump
//   m_mem_req/m_mem_ready        M-stage data-memory handshake
//   pc_stall, fbuf_stall, dbuf_stall, ebuf_stall   hold strobes
//   fbuf_flush, dbuf_flush, ebuf_flush             bubble strobes
//   pc_redirect_sel              PC mux selects the E target
//   ctrl_state                   current sequencer state
//
// Optional feature: define PIPE_HAZARD_CTRL_PERF_EN to add 32-bit wrapping
// event counters perf_ldstall, perf_flush and perf_memwait.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W        = REG_W_DEFAULT,
  parameter int FLUSH_CYCLES = 1,
  parameter int LDUSE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] d_src1,
  input  logic [REG_W-1:0] d_src2,
  input  logic             d_use1,
  input  logic             d_use2,
  input  logic [REG_W-1:0] e_dest,
  input  logic             e_reg_wr_en,
  input  logic             e_is_lw,
  input  logic             e_redirect,
  input  logic             m_mem_req,
  input  logic             m_mem_ready,
  output logic             pc_stall,
  output logic             fbuf_stall,
  output logic             dbuf_stall,
  output logic             ebuf_stall,
  output logic             fbuf_flush,
  output logic             dbuf_flush,
  output logic             ebuf_flush,
  output logic             pc_redirect_sel,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  output logic [31:0]      perf_ldstall,
  output logic [31:0]      perf_flush,
  output logic [31:0]      perf_memwait,
`endif
  output logic [1:0]       ctrl_state
);

  // Counter reload values; guarded so an unused configuration never
  // produces a negative reload.
  localparam logic [2:0] FLUSH_RELOAD = (FLUSH_CYCLES > 0) ? 3'(FLUSH_CYCLES - 1) : 3'd0;
  localparam logic [2:0] LDUSE_RELOAD = (LDUSE_CYCLES > 1) ? 3'(LDUSE_CYCLES - 2) : 3'd0;

  ctrl_state_e state_r;
  ctrl_state_e state_nxt_s;
  logic [2:0]  cnt_r;
  logic [2:0]  cnt_nxt_s;

  logic ldhaz_s;
  logic memhold_s;
  logic redir_go_s;
  logic ld_go_s;

  logic pc_stall_s;
  logic fbuf_stall_s;
  logic dbuf_stall_s;
  logic ebuf_stall_s;
  logic fbuf_flush_s;
  logic dbuf_flush_s;
  logic pc_redirect_sel_s;

  hazard_cmp #(
    .REG_W (REG_W)
  ) u_hazard_cmp (
    .d_src1      (d_src1),
    .d_src2      (d_src2),
    .d_use1      (d_use1),
    .d_use2      (d_use2),
    .e_dest      (e_dest),
    .e_reg_wr_en (e_reg_wr_en),
    .e_is_lw     (e_is_lw),
    .ldhaz       (ldhaz_s)
  );

  assign memhold_s = m_mem_req & ~m_mem_ready;

  // Sequencer state and counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_RUN;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and Mealy strobe decode.
  always_comb begin
    state_nxt_s       = state_r;
    cnt_nxt_s         = cnt_r;
    redir_go_s        = 1'b0;
    ld_go_s           = 1'b0;
    pc_stall_s        = 1'b0;
    fbuf_stall_s      = 1'b0;
    dbuf_stall_s      = 1'b0;
    ebuf_stall_s      = 1'b0;
    fbuf_flush_s      = 1'b0;
    dbuf_flush_s      = 1'b0;
    pc_redirect_sel_s = 1'b0;

    if (memhold_s) begin
      // Memory wait freezes the whole front end; redirect/load-use stay
      // pending on their inputs and are picked up once memory is ready.
      pc_stall_s   = 1'b1;
      fbuf_stall_s = 1'b1;
      dbuf_stall_s = 1'b1;
      ebuf_stall_s = 1'b1;
      state_nxt_s  = ST_MEMWAIT;
    end else begin
      case (state_r)
        ST_REDIR: begin
          if (e_redirect) begin
            redir_go_s = 1'b1;
          end else begin
            // D holds a wrong-path instruction here, so a load-use match
            // on it is meaningless and is not acted upon.
            fbuf_flush_s = 1'b1;
            dbuf_flush_s = 1'b1;
            if (cnt_r == 3'd0) begin
              state_nxt_s = ST_RUN;
            end else begin
              cnt_nxt_s = cnt_r - 3'd1;
            end
          end
        end
        ST_LDUSE: begin
          if (e_redirect) begin
            redir_go_s = 1'b1;
          end else begin
            pc_stall_s   = 1'b1;
            fbuf_stall_s = 1'b1;
            dbuf_flush_s = 1'b1;
            if (cnt_r == 3'd0) begin
              state_nxt_s = ST_RUN;
            end else begin
              cnt_nxt_s = cnt_r - 3'd1;
            end
          end
        end
        ST_RUN, ST_MEMWAIT: begin
          // Leaving MEMWAIT behaves exactly like RUN in the ready cycle.
          if (e_redirect) begin
            redir_go_s = 1'b1;
          end else if (ldhaz_s) begin
            ld_go_s = 1'b1;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        default: begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = 3'd0;
        end
      endcase

      if (redir_go_s) begin
        pc_redirect_sel_s = 1'b1;
        fbuf_flush_s      = 1'b1;
        dbuf_flush_s      = 1'b1;
        if (FLUSH_CYCLES > 0) begin
          state_nxt_s = ST_REDIR;
          cnt_nxt_s   = FLUSH_RELOAD;
        end else begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = 3'd0;
        end
      end else if (ld_go_s) begin
        // Hold PC/F, bubble D so a nop enters E behind the load.
        pc_stall_s   = 1'b1;
        fbuf_stall_s = 1'b1;
        dbuf_flush_s = 1'b1;
        if (LDUSE_CYCLES > 1) begin
          state_nxt_s = ST_LDUSE;
          cnt_nxt_s   = LDUSE_RELOAD;
        end else begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = 3'd0;
        end
      end else begin
        cnt_nxt_s = cnt_nxt_s;
      end
    end
  end

  // Outputs are gated by reset_n so they drop the instant reset asserts.
  assign pc_stall        = reset_n & pc_stall_s;
  assign fbuf_stall      = reset_n & fbuf_stall_s;
  assign dbuf_stall      = reset_n & dbuf_stall_s;
  assign ebuf_stall      = reset_n & ebuf_stall_s;
  assign fbuf_flush      = reset_n & fbuf_flush_s;
  assign dbuf_flush      = reset_n & dbuf_flush_s;
  // No hazard ever bubbles the E buffer from here; the line is owned and
  // held inactive so nothing else drives it.
  assign ebuf_flush      = 1'b0;
  assign pc_redirect_sel = reset_n & pc_redirect_sel_s;
  assign ctrl_state      = state_r & {2{reset_n}};

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  // Event counters; the load-use strobe set is the only one that combines
  // pc_stall with dbuf_flush, and ebuf_stall only occurs in a memory wait.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_ldstall <= 32'd0;
      perf_flush   <= 32'd0;
      perf_memwait <= 32'd0;
    end else begin
      if (pc_stall_s && dbuf_flush_s) begin
        perf_ldstall <= perf_ldstall + 32'd1;
      end
      if (fbuf_flush_s) begin
        perf_flush <= perf_flush + 32'd1;
      end
      if (ebuf_stall_s) begin
        perf_memwait <= perf_memwait + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default-parameter instance driven
// from a vector table, plus a FLUSH_CYCLES=3 / LDUSE_CYCLES=2 instance
// exercised by hand-written multi-cycle sequences.
module tb_pipe_hazard_ctrl;

  localparam logic [7:0] O_IDLE = 8'b0000_0000;
  localparam logic [7:0] O_LD   = 8'b1100_0100;
  localparam logic [7:0] O_RD   = 8'b0000_1101;
  localparam logic [7:0] O_FL   = 8'b0000_1100;
  localparam logic [7:0] O_MW   = 8'b1111_0000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] d_src1, d_src2, e_dest;
  logic       d_use1, d_use2, e_reg_wr_en, e_is_lw, e_redirect, m_mem_req, m_mem_ready;

  logic       a_pcs, a_fs, a_ds, a_es, a_ff, a_df, a_ef, a_rs;
  logic [1:0] a_st;
  logic       b_pcs, b_fs, b_ds, b_es, b_ff, b_df, b_ef, b_rs;
  logic [1:0] b_st;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] a_pl, a_pf, a_pm, b_pl, b_pf, b_pm;
`endif

  logic [9:0] obs_a, obs_b;
  assign obs_a = {a_pcs, a_fs, a_ds, a_es, a_ff, a_df, a_ef, a_rs, a_st};
  assign obs_b = {b_pcs, b_fs, b_ds, b_es, b_ff, b_df, b_ef, b_rs, b_st};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(4), .FLUSH_CYCLES(1), .LDUSE_CYCLES(1)) dut (
    .clk(clk), .reset_n(reset_n), .d_src1(d_src1), .d_src2(d_src2),
    .d_use1(d_use1), .d_use2(d_use2), .e_dest(e_dest), .e_reg_wr_en(e_reg_wr_en),
    .e_is_lw(e_is_lw), .e_redirect(e_redirect), .m_mem_req(m_mem_req),
    .m_mem_ready(m_mem_ready), .pc_stall(a_pcs), .fbuf_stall(a_fs),
    .dbuf_stall(a_ds), .ebuf_stall(a_es), .fbuf_flush(a_ff), .dbuf_flush(a_df),
    .ebuf_flush(a_ef), .pc_redirect_sel(a_rs),
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    .perf_ldstall(a_pl), .perf_flush(a_pf), .perf_memwait(a_pm),
`endif
    .ctrl_state(a_st)
  );

  pipe_hazard_ctrl #(.REG_W(4), .FLUSH_CYCLES(3), .LDUSE_CYCLES(2)) dut3 (
    .clk(clk), .reset_n(reset_n), .d_src1(d_src1), .d_src2(d_src2),
    .d_use1(d_use1), .d_use2(d_use2), .e_dest(e_dest), .e_reg_wr_en(e_reg_wr_en),
    .e_is_lw(e_is_lw), .e_redirect(e_redirect), .m_mem_req(m_mem_req),
    .m_mem_ready(m_mem_ready), .pc_stall(b_pcs), .fbuf_stall(b_fs),
    .dbuf_stall(b_ds), .ebuf_stall(b_es), .fbuf_flush(b_ff), .dbuf_flush(b_df),
    .ebuf_flush(b_ef), .pc_redirect_sel(b_rs),
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    .perf_ldstall(b_pl), .perf_flush(b_pf), .perf_memwait(b_pm),
`endif
    .ctrl_state(b_st)
  );

  typedef struct {
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] uses;  // {d_use1, d_use2}
    logic [3:0] dst;
    logic [1:0] wl;    // {e_reg_wr_en, e_is_lw}
    logic [2:0] ev;    // {e_redirect, m_mem_req, m_mem_ready}
    logic [9:0] exp;   // {8 strobes, ctrl_state}
  } vec_t;

  int tests = 0;
  int fails = 0;
  vec_t tbl[35];

  function automatic vec_t mk(input logic [3:0] s1, input logic [3:0] s2,
                              input logic [1:0] uses, input logic [3:0] dst,
                              input logic [1:0] wl, input logic [2:0] ev,
                              input logic [7:0] o, input logic [1:0] st);
    vec_t v;
    v.s1 = s1; v.s2 = s2; v.uses = uses; v.dst = dst;
    v.wl = wl; v.ev = ev; v.exp = {o, st};
    return v;
  endfunction

  // ldhaz on src1 with the given event bits; idle vector with given expectation
  function automatic vec_t ldv(input logic [2:0] ev, input logic [7:0] o, input logic [1:0] st);
    return mk(4'd9, 4'd0, 2'b10, 4'd9, 2'b11, ev, o, st);
  endfunction

  function automatic vec_t idv(input logic [2:0] ev, input logic [7:0] o, input logic [1:0] st);
    return mk(4'd0, 4'd0, 2'b00, 4'd0, 2'b00, ev, o, st);
  endfunction

  task automatic drive(input vec_t v);
    d_src1 = v.s1; d_src2 = v.s2; {d_use1, d_use2} = v.uses; e_dest = v.dst;
    {e_reg_wr_en, e_is_lw} = v.wl; {e_redirect, m_mem_req, m_mem_ready} = v.ev;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic cyc(input vec_t v);
    drive(v);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(idv(3'b000, O_IDLE, 2'd0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = idv(3'b000, O_IDLE, 2'd0);
    tbl[1]  = mk(4'd5, 4'd0, 2'b10, 4'd5, 2'b11, 3'b000, O_LD, 2'd0);
    tbl[2]  = idv(3'b000, O_IDLE, 2'd0);
    tbl[3]  = mk(4'd0, 4'd3, 2'b01, 4'd3, 2'b11, 3'b000, O_LD, 2'd0);
    tbl[4]  = mk(4'd3, 4'd3, 2'b00, 4'd3, 2'b11, 3'b000, O_IDLE, 2'd0);
    tbl[5]  = mk(4'd5, 4'd0, 2'b10, 4'd5, 2'b01, 3'b000, O_IDLE, 2'd0);
    tbl[6]  = mk(4'd5, 4'd0, 2'b10, 4'd5, 2'b10, 3'b000, O_IDLE, 2'd0);
    tbl[7]  = mk(4'd0, 4'd0, 2'b10, 4'd0, 2'b11, 3'b000, O_LD, 2'd0);
    tbl[8]  = mk(4'd5, 4'd6, 2'b11, 4'd7, 2'b11, 3'b000, O_IDLE, 2'd0);
    tbl[9]  = idv(3'b100, O_RD, 2'd0);
    tbl[10] = idv(3'b000, O_FL, 2'd2);
    tbl[11] = idv(3'b000, O_IDLE, 2'd0);
    tbl[12] = idv(3'b010, O_MW, 2'd0);
    tbl[13] = idv(3'b010, O_MW, 2'd3);
    tbl[14] = idv(3'b011, O_IDLE, 2'd3);
    tbl[15] = idv(3'b000, O_IDLE, 2'd0);
    tbl[16] = ldv(3'b100, O_RD, 2'd0);
    tbl[17] = ldv(3'b000, O_FL, 2'd2);
    tbl[18] = ldv(3'b000, O_LD, 2'd0);
    tbl[19] = idv(3'b100, O_RD, 2'd0);
    tbl[20] = idv(3'b100, O_RD, 2'd2);
    tbl[21] = idv(3'b000, O_FL, 2'd2);
    tbl[22] = idv(3'b000, O_IDLE, 2'd0);
    tbl[23] = ldv(3'b110, O_MW, 2'd0);
    tbl[24] = ldv(3'b110, O_MW, 2'd3);
    tbl[25] = ldv(3'b111, O_RD, 2'd3);
    tbl[26] = idv(3'b000, O_FL, 2'd2);
    tbl[27] = idv(3'b000, O_IDLE, 2'd0);
    tbl[28] = idv(3'b100, O_RD, 2'd0);
    tbl[29] = idv(3'b010, O_MW, 2'd2);
    tbl[30] = idv(3'b011, O_IDLE, 2'd3);
    tbl[31] = idv(3'b000, O_IDLE, 2'd0);
    tbl[32] = idv(3'b010, O_MW, 2'd0);
    tbl[33] = ldv(3'b011, O_LD, 2'd3);
    tbl[34] = idv(3'b001, O_IDLE, 2'd0);

    // Reset: strobes stay low even with every hazard input active.
    reset_n = 1'b0;
    drive(ldv(3'b110, O_IDLE, 2'd0));
    #2 check("reset_gate_a", 32'(obs_a), 32'd0);
    check("reset_gate_b", 32'(obs_b), 32'd0);
    drive(ldv(3'b100, O_IDLE, 2'd0));
    #1 check("reset_gate_redir", 32'(obs_a), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 35; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(obs_a), 32'(tbl[i].exp));
      @(posedge clk); #1;
    end

    // Load-use with LDUSE_CYCLES=2 vs 1.
    do_reset();
    drive(ldv(3'b000, O_IDLE, 2'd0));
    @(negedge clk);
    check("ld2_c0", 32'(obs_b), 32'({O_LD, 2'd0}));
    check("ld1_c0", 32'(obs_a), 32'({O_LD, 2'd0}));
    @(posedge clk); #1;
    drive(idv(3'b000, O_IDLE, 2'd0));
    @(negedge clk);
    check("ld2_c1", 32'(obs_b), 32'({O_LD, 2'd1}));
    check("ld1_c1", 32'(obs_a), 32'({O_IDLE, 2'd0}));
    @(posedge clk); #1;
    @(negedge clk);
    check("ld2_c2", 32'(obs_b), 32'({O_IDLE, 2'd0}));
    @(posedge clk); #1;

    // Redirect with FLUSH_CYCLES=3, reset abandons it at cnt=2.
    drive(idv(3'b100, O_IDLE, 2'd0));
    @(negedge clk);
    check("fl3_c0", 32'(obs_b), 32'({O_RD, 2'd0}));
    @(posedge clk); #1;
    drive(idv(3'b000, O_IDLE, 2'd0));
    @(negedge clk);
    check("fl3_c1", 32'(obs_b), 32'({O_FL, 2'd2}));
    #1 drive(ldv(3'b100, O_IDLE, 2'd0));
    #1 check("fl3_rearm", 32'(obs_b), 32'({O_RD, 2'd2}));
    #1 reset_n = 1'b0;
    #1 check("rst_async_b", 32'(obs_b), 32'd0);
    check("rst_async_a", 32'(obs_a), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    drive(idv(3'b000, O_IDLE, 2'd0));
    @(negedge clk);
    check("rst_rel_b", 32'(obs_b), 32'({O_IDLE, 2'd0}));
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_rel_b2", 32'(obs_b), 32'({O_IDLE, 2'd0}));
    @(posedge clk); #1;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    do_reset();
    cyc(ldv(3'b000, O_IDLE, 2'd0));
    cyc(idv(3'b000, O_IDLE, 2'd0));
    cyc(ldv(3'b000, O_IDLE, 2'd0));
    cyc(idv(3'b000, O_IDLE, 2'd0));
    cyc(idv(3'b100, O_IDLE, 2'd0));
    cyc(idv(3'b000, O_IDLE, 2'd0));
    cyc(idv(3'b000, O_IDLE, 2'd0));
    @(negedge clk);
    check("perf_ldstall", a_pl, 32'd2);
    check("perf_flush", a_pf, 32'd2);
    check("perf_memwait", a_pm, 32'd0);
    cyc(idv(3'b010, O_IDLE, 2'd0));
    cyc(idv(3'b010, O_IDLE, 2'd0));
    cyc(idv(3'b011, O_IDLE, 2'd0));
    @(negedge clk);
    check("perf_memwait2", a_pm, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
